// File: rtl/fraud_pkg.sv
// Shared definitions for the fraud decision scheduler: result layout,
// default threshold and FSM state encoding.
package fraud_pkg;

  localparam int          RESULT_W          = 32;
  localparam int          MAX_LSB           = 16;
  localparam int          IDX_LSB           = 8;
  localparam int          FLAG_BIT          = 0;
  localparam int unsigned DEFAULT_THRESHOLD = 2048;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/decision_fifo.sv
// Synchronous result FIFO with a registered head word; head reads as zero
// whenever the FIFO is empty.
module decision_fifo
  import fraud_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_push,
  input  logic [RESULT_W-1:0] i_wdata,
  input  logic                i_pop,
  output logic                o_full,
  output logic                o_empty,
  output logic [RESULT_W-1:0] o_head,
  output logic                o_head_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [RESULT_W-1:0] mem_q [DEPTH];
  logic [RESULT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RESULT_W-1:0] head_q, head_d;
  logic                head_valid_q, head_valid_d;
  logic                do_push, do_pop;

  assign o_full       = (cnt_q == CNT_W'(DEPTH));
  assign o_empty      = (cnt_q == '0);
  assign do_pop       = i_pop && !o_empty;
  assign do_push      = i_push && (!o_full || do_pop);
  assign o_head       = head_q;
  assign o_head_valid = head_valid_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = i_wdata;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Head is computed from next-state so it is a true register and never bubbles.
    head_valid_d = (cnt_d != '0);
    head_d       = head_valid_d ? mem_d[rd_d] : '0;
  end

  // NOTE: storage is not reset; the head is forced to zero while empty so stale words never escape.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

endmodule

// File: rtl/fraud_decision_scheduler.sv
// Scans a score vector one element per clock for max/argmax, applies the fraud
// threshold and queues {max, idx, flag} results toward the host readout.
module fraud_decision_scheduler
  import fraud_pkg::*;
#(
  parameter int          NUM_INPUT   = 10,
  parameter int          INPUT_WIDTH = 16,
  parameter int unsigned THRESHOLD   = DEFAULT_THRESHOLD,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_INPUT*INPUT_WIDTH-1:0] i_data,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic [RESULT_W-1:0]              o_data,
  output logic                             o_data_valid,
  input  logic                             i_ready,
  output logic [15:0]                      o_fraud_count,
  output logic                             o_busy
);

  localparam int         VEC_W    = NUM_INPUT * INPUT_WIDTH;
  localparam logic [7:0] LAST_IDX = 8'(NUM_INPUT - 1);

  state_e                 state_q;
  logic                   ready_q;
  logic [VEC_W-1:0]       scan_q;
  logic [INPUT_WIDTH-1:0] max_q;
  logic [7:0]             idx_q;
  logic [7:0]             cnt_q;
  logic [15:0]            fraud_cnt_q;

  logic [INPUT_WIDTH-1:0] cur_elem;
  logic [15:0]            max_ext;
  logic                   flag;
  logic [RESULT_W-1:0]    result;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop;

  // The buffer shifts down each SCAN cycle, so the element under test is always at the bottom.
  assign cur_elem = scan_q[INPUT_WIDTH-1:0];
  assign max_ext  = 16'(max_q);
  assign flag     = 32'(max_ext) > THRESHOLD;
  assign pop      = !fifo_empty && i_ready;
  assign push     = (state_q == WRITE) && (!fifo_full || pop);

  always_comb begin
    result                   = '0;
    result[MAX_LSB +: 16]    = max_ext;
    result[IDX_LSB +: 8]     = idx_q;
    result[FLAG_BIT]         = flag;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      scan_q      <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      fraud_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid && ready_q) begin
            scan_q  <= i_data >> INPUT_WIDTH;
            max_q   <= i_data[INPUT_WIDTH-1:0];
            idx_q   <= '0;
            cnt_q   <= 8'd1;
            ready_q <= 1'b0;
            if (NUM_INPUT == 1) state_q <= WRITE;
            else                state_q <= SCAN;
          end else begin
            ready_q <= 1'b1;
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (cur_elem > max_q) begin
            max_q <= cur_elem;
            idx_q <= cnt_q;
          end
          scan_q <= scan_q >> INPUT_WIDTH;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) state_q <= WRITE;
        end
        WRITE: begin
          if (push) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
            if (flag && (fraud_cnt_q != 16'hFFFF)) fraud_cnt_q <= fraud_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  decision_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (push),
    .i_wdata     (result),
    .i_pop       (pop),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_head      (o_data),
    .o_head_valid(o_data_valid)
  );

  assign o_ready       = ready_q;
  assign o_fraud_count = fraud_cnt_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fraud_decision_scheduler.sv
// Directed, table-driven bench for fraud_decision_scheduler with hand-computed results.
module tb_fraud_decision_scheduler;

  localparam int N  = 10;
  localparam int W  = 16;
  localparam int VW = N * W;

  typedef struct {
    logic [VW-1:0] data;
    logic [31:0]   exp;
  } vec_t;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [VW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic [31:0]   o_data;
  logic          o_data_valid;
  logic          i_ready;
  logic [15:0]   o_fraud_count;
  logic          o_busy;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] exp_fraud   = 16'h0;
  vec_t        tbl [9];
  logic [31:0] bp_exp [5];

  fraud_decision_scheduler #(
    .NUM_INPUT  (N),
    .INPUT_WIDTH(W),
    .THRESHOLD  (2048),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_ready      (i_ready),
    .o_fraud_count(o_fraud_count),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] one_hot(input int k, input logic [15:0] v);
    logic [VW-1:0] r;
    r = '0;
    r[k*W +: W] = v;
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic f);
    return (f && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (!o_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) check({name, " ready_timeout"}, 32'(o_ready), 32'd1);
  endtask

  // Offer one vector with i_ready high and check result, latency and fraud count.
  task automatic run_vec(input logic [VW-1:0] d, input logic [31:0] exp, input string name);
    int c;
    wait_ready(name);
    i_data  = d;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    c = 1;
    check({name, " busy"}, 32'(o_busy), 32'd1);
    while (!o_data_valid && c < 60) begin
      @(negedge i_clk);
      c++;
    end
    check({name, " data"}, o_data, exp);
    check({name, " latency"}, 32'(c), 32'd11);
    exp_fraud = sat_inc(exp_fraud, exp[0]);
    check({name, " fraud_count"}, 32'(o_fraud_count), 32'(exp_fraud));
  endtask

  initial begin
    int extra;
    logic changed;

    tbl[0].data = one_hot(3, 16'd3000);                          tbl[0].exp = 32'h0BB8_0301;
    tbl[1].data = one_hot(2, 16'd1500) | one_hot(7, 16'd1500);   tbl[1].exp = 32'h05DC_0200;
    tbl[2].data = one_hot(5, 16'd2048);                          tbl[2].exp = 32'h0800_0500;
    tbl[3].data = one_hot(1, 16'd2049);                          tbl[3].exp = 32'h0801_0101;
    tbl[4].data = one_hot(9, 16'hFFFF);                          tbl[4].exp = 32'hFFFF_0901;
    tbl[5].data = '0;                                            tbl[5].exp = 32'h0000_0000;
    tbl[6].data = one_hot(0, 16'd100) | one_hot(4, 16'd100) | one_hot(8, 16'd99);
    tbl[6].exp  = 32'h0064_0000;
    tbl[7].data = '0;
    for (int k = 0; k < N; k++) tbl[7].data |= one_hot(k, 16'(300 * k));
    tbl[7].exp  = 32'h0A8C_0901;
    tbl[8].data = one_hot(6, 16'd4096) | one_hot(2, 16'd4095);   tbl[8].exp = 32'h1000_0601;

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;

    // Reset state and o_ready rising one cycle after release.
    repeat (2) @(negedge i_clk);
    check("rst ready", 32'(o_ready), 32'd0);
    check("rst valid", 32'(o_data_valid), 32'd0);
    check("rst data", o_data, 32'd0);
    check("rst count", 32'(o_fraud_count), 32'd0);
    check("rst busy", 32'(o_busy), 32'd0);
    i_rst_n = 1'b1;
    check("post_rst ready_first_cycle", 32'(o_ready), 32'd0);
    @(negedge i_clk);
    check("post_rst ready_second_cycle", 32'(o_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(tbl[i].data, tbl[i].exp, $sformatf("vec%0d", i));

    // i_valid pulsed mid-SCAN must not produce another result.
    wait_ready("pulse");
    i_data  = one_hot(4, 16'd2500);
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    i_data  = one_hot(0, 16'd5000);
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    extra = 0;
    while (!o_data_valid && extra < 60) begin
      @(negedge i_clk);
      extra++;
    end
    check("pulse data", o_data, 32'h09C4_0401);
    exp_fraud = sat_inc(exp_fraud, 1'b1);
    extra = 0;
    repeat (25) begin
      @(negedge i_clk);
      if (o_data_valid) extra++;
    end
    check("pulse extra_results", 32'(extra), 32'd0);

    // Backpressure: four queue up, the fifth waits in WRITE.
    i_ready = 1'b0;
    for (int v = 0; v < 5; v++) begin
      bp_exp[v] = {16'(3000 + v), 8'(v), 8'h01};
      wait_ready($sformatf("bp%0d", v));
      i_data  = one_hot(v, 16'(3000 + v));
      i_valid = 1'b1;
      @(negedge i_clk);
      i_valid = 1'b0;
    end
    for (int v = 0; v < 4; v++) exp_fraud = sat_inc(exp_fraud, 1'b1);
    changed = 1'b0;
    repeat (20) begin
      @(negedge i_clk);
      if (!o_data_valid || o_data !== bp_exp[0]) changed = 1'b1;
    end
    check("bp held_head_changed", 32'(changed), 32'd0);
    check("bp stall busy", 32'(o_busy), 32'd1);
    check("bp stall ready", 32'(o_ready), 32'd0);
    check("bp stall count", 32'(o_fraud_count), 32'(exp_fraud));
    i_ready = 1'b1;
    check("bp pop0", o_data, bp_exp[0]);
    for (int k = 1; k < 5; k++) begin
      @(negedge i_clk);
      check($sformatf("bp pop%0d valid", k), 32'(o_data_valid), 32'd1);
      check($sformatf("bp pop%0d", k), o_data, bp_exp[k]);
      if (k == 1) begin
        exp_fraud = sat_inc(exp_fraud, 1'b1);
        check("bp fifth_pushed count", 32'(o_fraud_count), 32'(exp_fraud));
        check("bp fifth_pushed busy", 32'(o_busy), 32'd0);
      end
    end
    @(negedge i_clk);
    check("bp drained valid", 32'(o_data_valid), 32'd0);

    // Reset asserted at cnt=5 discards the in-flight vector and clears the counter.
    wait_ready("midrst");
    i_data  = one_hot(2, 16'd4000);
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("midrst ready", 32'(o_ready), 32'd0);
    check("midrst valid", 32'(o_data_valid), 32'd0);
    check("midrst data", o_data, 32'd0);
    check("midrst count", 32'(o_fraud_count), 32'd0);
    check("midrst busy", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    i_rst_n   = 1'b1;
    exp_fraud = 16'h0;
    extra = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_data_valid) extra++;
    end
    check("midrst late_results", 32'(extra), 32'd0);
    run_vec(one_hot(8, 16'd2100), 32'h0834_0801, "after_rst");

    // Counter saturation from a preloaded 0xFFFE.
    @(negedge i_clk);
    force dut.fraud_cnt_q = 16'hFFFE;
    @(negedge i_clk);
    release dut.fraud_cnt_q;
    exp_fraud = 16'hFFFE;
    check("sat preload", 32'(o_fraud_count), 32'h0000_FFFE);
    run_vec(one_hot(1, 16'd3333), 32'h0D05_0101, "sat0");
    run_vec(one_hot(9, 16'd2049), 32'h0801_0901, "sat1");
    run_vec(one_hot(0, 16'd60000), 32'hEA60_0001, "sat2");

    repeat (3) @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
